// File: rtl/rng_collector_pkg.sv
// Shared constants for the RNG collector.
//   RNG_DEPTH_DEFAULT       : default FIFO depth in 32-bit words
//   RNG_FULL_THRESH_DEFAULT : default occupancy at which backpressure asserts
//   NIBBLES_PER_WORD        : 4-bit nibbles packed into one FIFO word
//   sat_add16()             : saturating add used by the drop counter
package rng_collector_pkg;

  localparam int unsigned RNG_DEPTH_DEFAULT       = 16;
  localparam int unsigned RNG_FULL_THRESH_DEFAULT = 14;
  localparam int unsigned NIBBLES_PER_WORD        = 8;
  localparam int unsigned NIB_IDX_W               = $clog2(NIBBLES_PER_WORD);
  localparam int unsigned OUTST_W                 = 4;
  localparam logic [OUTST_W-1:0] OUTST_MAX        = '1;

  // Adds 0..3 to a 16-bit counter, sticking at 0xFFFF instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/rng_word_fifo.sv
// First-word-fall-through FIFO of 32-bit words.
//   clk, rst_n     : clock, asynchronous active-low reset
//   push_i         : write push_data_i this cycle (if there is room)
//   push_data_i    : word to write
//   pop_i          : consume the head word (ignored when empty)
//   flush_i        : synchronous empty; wins over push and pop
//   push_drop_o    : push_i was refused because the FIFO was full without a pop
//   rd_data_o      : head word; holds its last value once the FIFO drains
//   rd_valid_o     : FIFO non-empty
//   level_o        : current word count (0..DEPTH)
module rng_word_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [31:0]              push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic                     push_drop_o,
  output logic [31:0]              rd_data_o,
  output logic                     rd_valid_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [31:0]   head_q, head_d;
  logic [31:0]   mem_q [DEPTH];
  logic          full;
  logic          do_pop;
  logic          do_push;

  assign full        = (level_q == LW'(DEPTH));
  assign do_pop      = pop_i && (level_q != '0) && !flush_i;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign do_push     = push_i && !flush_i && (!full || do_pop);
  assign push_drop_o = push_i && !flush_i && !do_push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    head_d   = head_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      // Registered head: when the slot being written becomes the head
      // (FIFO was empty or about to be), bypass the array read.
      if (level_d != '0) begin
        if (do_push && (wr_ptr_q == rd_ptr_d)) head_d = push_data_i;
        else                                   head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

  // Storage needs no reset: nothing reads a slot before it is written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign rd_data_o  = head_q;
  assign rd_valid_o = (level_q != '0);
  assign level_o    = level_q;

endmodule

// File: rtl/rng_collector.sv
// Collects random nibbles into 32-bit words and buffers them for the host.
//   clk, rst       : clock, asynchronous active-low reset
//   rng_issued     : pulse, one RNG read command accepted by the arbiter
//   rng_valid      : rng_bits carries a nibble this cycle
//   rng_bits       : random nibble
//   rng_fifo_full  : registered backpressure to the periodic RNG requester
//   flush          : synchronous clear of FIFO and partial word
//   rd_data        : head-of-FIFO word (first-word-fall-through)
//   rd_valid       : FIFO non-empty
//   rd_ready       : host accepts rd_data
//   fifo_level     : current word count
//   drop_cnt       : discarded nibbles + words, saturating at 0xFFFF
//
// Host handshake: a word transfers on every rising edge where rd_valid and
// rd_ready are both high; rd_valid never depends on rd_ready, and rd_data is
// stable while rd_valid is high until that transfer happens.
module rng_collector
  import rng_collector_pkg::*;
#(
  parameter int unsigned DEPTH       = RNG_DEPTH_DEFAULT,
  parameter int unsigned FULL_THRESH = RNG_FULL_THRESH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rng_issued,
  input  logic                   rng_valid,
  input  logic [3:0]             rng_bits,
  output logic                   rng_fifo_full,
  input  logic                   flush,
  output logic [31:0]            rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [15:0]            drop_cnt
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0]        THRESH_L = LW'(FULL_THRESH);
  localparam logic [NIB_IDX_W-1:0] LAST_IDX = NIB_IDX_W'(NIBBLES_PER_WORD - 1);

  logic [OUTST_W-1:0]   outst_q, outst_d;
  logic [NIB_IDX_W-1:0] idx_q, idx_d;
  logic [31:0]          word_q, word_d;
  logic                 push_q, push_d;
  logic [31:0]          push_word_q, push_word_d;
  logic                 full_q, full_d;
  logic [15:0]          drop_q, drop_d;

  logic                 accept;
  logic                 nib_drop;
  logic                 word_drop;
  logic                 pop;
  logic [LW-1:0]        level_w;

  // Nibbles are only trusted while a command is outstanding.
  assign accept   = rng_valid && (outst_q != '0);
  assign nib_drop = rng_valid && (outst_q == '0);
  assign pop      = rd_valid && rd_ready;

  always_comb begin
    outst_d     = outst_q;
    idx_d       = idx_q;
    word_d      = word_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;

    case ({rng_issued, accept})
      2'b10:   if (outst_q != OUTST_MAX) outst_d = outst_q + OUTST_W'(1);
      2'b01:   outst_d = outst_q - OUTST_W'(1);
      default: outst_d = outst_q;
    endcase

    if (accept) begin
      word_d[{idx_q, 2'b00} +: 4] = rng_bits;
      idx_d = idx_q + NIB_IDX_W'(1);
      // Last nibble: hand the finished word to a one-cycle push stage.
      if (idx_q == LAST_IDX) begin
        push_d      = 1'b1;
        push_word_d = word_d;
        word_d      = '0;
      end
    end

    if (word_drop) begin
      idx_d  = '0;
      word_d = '0;
    end

    if (flush) begin
      idx_d  = '0;
      word_d = '0;
      push_d = 1'b0;
    end

    full_d = (level_w >= THRESH_L);
    drop_d = sat_add16(drop_q, {1'b0, nib_drop} + {1'b0, word_drop});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outst_q     <= '0;
      idx_q       <= '0;
      word_q      <= '0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      full_q      <= 1'b0;
      drop_q      <= '0;
    end else begin
      outst_q     <= outst_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
      full_q      <= full_d;
      drop_q      <= drop_d;
    end
  end

  rng_word_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .push_i      (push_q),
    .push_data_i (push_word_q),
    .pop_i       (pop),
    .flush_i     (flush),
    .push_drop_o (word_drop),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid),
    .level_o     (level_w)
  );

  assign fifo_level    = level_w;
  assign rng_fifo_full = full_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_rng_collector.sv
module tb_rng_collector;

  localparam int DEPTH  = 16;
  localparam int THRESH = 14;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rng_issued = 1'b0;
  logic        rng_valid  = 1'b0;
  logic [3:0]  rng_bits   = '0;
  logic        flush      = 1'b0;
  logic        rd_ready   = 1'b0;
  logic        rng_fifo_full;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [4:0]  fifo_level;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  rng_collector #(.DEPTH(DEPTH), .FULL_THRESH(THRESH)) dut (
    .clk           (clk),
    .rst           (rst),
    .rng_issued    (rng_issued),
    .rng_valid     (rng_valid),
    .rng_bits      (rng_bits),
    .rng_fifo_full (rng_fifo_full),
    .flush         (flush),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .fifo_level    (fifo_level),
    .drop_cnt      (drop_cnt)
  );

  // ---------------- scoreboard / model ----------------
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          out_m;
  int          idx_m;
  logic [31:0] word_m;
  bit          pend_m;
  logic [31:0] pend_word_m;
  logic [15:0] drop_m;
  bit          full_m;
  logic [31:0] last_pop_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_level"}, 32'(fifo_level), 32'(exp_q.size()));
    chk({tag, "_valid"}, 32'(rd_valid), 32'(exp_q.size() > 0));
    chk({tag, "_drop"},  32'(drop_cnt), 32'(drop_m));
    chk({tag, "_full"},  32'(rng_fifo_full), 32'(full_m));
  endtask

  task automatic model_clear();
    exp_q.delete();
    out_m  = 0;
    idx_m  = 0;
    word_m = '0;
    pend_m = 1'b0;
    pend_word_m = '0;
    drop_m = '0;
    full_m = 1'b0;
    last_pop_m = '0;
  endtask

  task automatic drop_inc();
    if (drop_m != 16'hFFFF) drop_m = drop_m + 16'd1;
  endtask

  // One clock: update the model from the inputs currently driven, compare any
  // word the host takes this cycle, then advance to 1 ns after the edge.
  task automatic step();
    int  lvl_now;
    bit  pop_m;
    bit  acc;
    lvl_now = exp_q.size();
    pop_m   = rd_ready && (lvl_now > 0) && !flush;
    if (pop_m) begin
      chk("pop_data", rd_data, exp_q[0]);
      last_pop_m = exp_q.pop_front();
    end
    if (flush) begin
      exp_q.delete();
      pend_m = 1'b0;
      idx_m  = 0;
      word_m = '0;
    end else if (pend_m) begin
      if (lvl_now < DEPTH || pop_m) exp_q.push_back(pend_word_m);
      else begin
        drop_inc();
        idx_m  = 0;
        word_m = '0;
      end
      pend_m = 1'b0;
    end
    acc = rng_valid && (out_m > 0);
    if (rng_valid && out_m == 0) drop_inc();
    if (acc && !flush) begin
      word_m[idx_m*4 +: 4] = rng_bits;
      if (idx_m == 7) begin
        pend_m      = 1'b1;
        pend_word_m = word_m;
        word_m      = '0;
        idx_m       = 0;
      end else begin
        idx_m++;
      end
    end
    if (rng_issued && !acc && out_m < 15) out_m++;
    else if (acc && !rng_issued) out_m--;
    full_m = (lvl_now >= THRESH);
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b0;
    rng_issued = 1'b0;
    rng_valid  = 1'b0;
    flush      = 1'b0;
    rd_ready   = 1'b0;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic issue(input int n);
    rng_issued = 1'b1;
    repeat (n) step();
    rng_issued = 1'b0;
  endtask

  task automatic nib(input logic [3:0] b);
    rng_valid = 1'b1;
    rng_bits  = b;
    step();
    rng_valid = 1'b0;
  endtask

  // Leaves the completed word one edge away from entering the FIFO.
  task automatic pack_word(input logic [31:0] w);
    issue(8);
    for (int k = 0; k < 8; k++) nib(w[4*k +: 4]);
  endtask

  task automatic send_word(input logic [31:0] w);
    pack_word(w);
    step();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] drop_save;

    // reset state
    do_reset();
    chk("rst_data", rd_data, 32'h0);
    check_state("rst");

    // two issues, then nibbles 1..8 each preceded by four issues
    issue(2);
    for (int k = 0; k < 8; k++) begin
      issue(4);
      nib(4'(k + 1));
    end
    step();
    chk("pack_data", rd_data, 32'h87654321);
    check_state("pack");
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check_state("pack_drain");

    // nibble with nothing outstanding is dropped
    do_reset();
    nib(4'h9);
    chk("orphan_drop", 32'(drop_cnt), 32'd1);
    check_state("orphan");

    // backpressure threshold with rd_ready held low
    do_reset();
    for (int i = 0; i < 14; i++) send_word($urandom());
    check_state("lvl14");
    chk("full_before", 32'(rng_fifo_full), 32'd0);
    step();
    chk("full_at14", 32'(rng_fifo_full), 32'd1);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check_state("lvl13");
    step();
    chk("full_release", 32'(rng_fifo_full), 32'd0);

    // fill to DEPTH, then a completing word with and without a same-cycle pop
    for (int i = 0; i < 3; i++) send_word($urandom());
    check_state("lvl16");
    drop_save = drop_cnt;
    pack_word($urandom());
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("full_pop_level", 32'(fifo_level), 32'd16);
    chk("full_pop_drop", 32'(drop_cnt), 32'(drop_save));
    pack_word($urandom());
    step();
    chk("full_drop_level", 32'(fifo_level), 32'd16);
    chk("full_drop_cnt", 32'(drop_cnt), 32'(drop_save + 16'd1));
    check_state("after_drop");
    rd_ready = 1'b1;
    repeat (16) step();
    rd_ready = 1'b0;
    check_state("drained");
    chk("hold_data", rd_data, last_pop_m);

    // flush mid-word, next word starts fresh at bits [3:0]
    do_reset();
    issue(8);
    for (int k = 0; k < 5; k++) nib(4'(k + 1));
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_state("flush");
    send_word(32'hFEDCBA98);
    chk("flush_fresh", rd_data, 32'hFEDCBA98);
    check_state("flush_word");

    // random traffic with a wobbling rd_ready
    for (int i = 0; i < 6; i++) begin
      issue($urandom_range(8, 10));
      for (int k = 0; k < 8; k++) begin
        rd_ready = 1'($urandom_range(0, 1));
        nib(4'($urandom_range(0, 15)));
      end
      step();
    end
    rd_ready = 1'b1;
    repeat (10) step();
    rd_ready = 1'b0;
    check_state("random");

    // asynchronous reset mid-word with a read in flight
    send_word($urandom());
    issue(5);
    nib(4'h3);
    nib(4'h4);
    rd_ready = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_valid", 32'(rd_valid), 32'd0);
    chk("arst_data", rd_data, 32'h0);
    chk("arst_full", 32'(rng_fifo_full), 32'd0);
    chk("arst_drop", 32'(drop_cnt), 32'd0);
    do_reset();
    nib(4'h7);
    chk("post_rst_drop", 32'(drop_cnt), 32'd1);
    check_state("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
